// File: rtl/obj_slot_bank.sv
// obj_slot_bank: fixed bank of falling-object slots with spawn, tick advance, hit clear and miss counting
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   spawn, lane           request to place an object in a lane
//   spawn_ack, spawn_err  combinational accept / reject of this cycle's spawn
//   tick                  advance every live object by Y_STEP
//   clr, clr_idx          free one slot (hit)
//   valid, x_flat, y_flat per-slot state, slot i at [i*W +: W]
//   full, count           occupancy derived from registered valid
//   miss, miss_cnt        retire pulse and saturating retire counter
module obj_slot_bank #(
    parameter int N_SLOTS     = 10,
    parameter int LANE_W      = 4,
    parameter int N_LANES     = 12,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int LANE_PITCH  = 10,
    parameter int LANE_OFFSET = 2,
    parameter int Y_MAX       = 119,
    parameter int Y_STEP      = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              spawn,
    input  logic [LANE_W-1:0]                 lane,
    output logic                              spawn_ack,
    output logic                              spawn_err,
    input  logic                              tick,
    input  logic                              clr,
    input  logic [$clog2(N_SLOTS)-1:0]        clr_idx,
    output logic [N_SLOTS-1:0]                valid,
    output logic [N_SLOTS*X_W-1:0]            x_flat,
    output logic [N_SLOTS*Y_W-1:0]            y_flat,
    output logic                              full,
    output logic [$clog2(N_SLOTS+1)-1:0]      count,
    output logic                              miss,
    output logic [7:0]                        miss_cnt
);
    localparam int CNT_W = $clog2(N_SLOTS + 1);
    logic [X_W-1:0]     x_q [N_SLOTS];
    logic [Y_W-1:0]     y_q [N_SLOTS];
    logic [Y_W:0]       y_inc [N_SLOTS];
    logic [N_SLOTS-1:0] fits, clr_vec, retire, inv, alloc;
    logic [CNT_W-1:0]   n_ret;
    logic [X_W-1:0]     new_x;
    logic [8:0]         cnt_sum;
    assign full      = (count == CNT_W'(N_SLOTS));
    assign spawn_ack = reset_n & spawn & (int'(lane) < N_LANES) & ~full;
    assign spawn_err = spawn & ~spawn_ack;
    assign inv       = ~valid;
    // isolate the lowest invalid slot: x & -x
    assign alloc     = spawn_ack ? (inv & (~inv + N_SLOTS'(1))) : '0;
    assign new_x     = X_W'(int'(lane) * LANE_PITCH + LANE_OFFSET);
    assign cnt_sum   = {1'b0, miss_cnt} + 9'(n_ret);
    always_comb begin
        count = '0;
        n_ret = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            y_inc[i]   = {1'b0, y_q[i]} + (Y_W+1)'(Y_STEP);
            fits[i]    = y_inc[i] <= (Y_W+1)'(Y_MAX);
            clr_vec[i] = clr && (int'(clr_idx) == i);
            // a hit on the same edge takes precedence over falling off the bottom
            retire[i]  = tick & valid[i] & ~fits[i] & ~clr_vec[i];
            count      = count + CNT_W'(valid[i]);
            n_ret      = n_ret + CNT_W'(retire[i]);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid    <= '0;
            miss     <= 1'b0;
            miss_cnt <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (alloc[i]) begin
                    valid[i] <= 1'b1;
                    x_q[i]   <= new_x;
                    y_q[i]   <= '0;
                end else if (clr_vec[i] && valid[i]) begin
                    valid[i] <= 1'b0;
                end else if (tick && valid[i]) begin
                    if (fits[i]) y_q[i] <= y_inc[i][Y_W-1:0];
                    else valid[i] <= 1'b0;
                end
            end
            miss     <= |retire;
            miss_cnt <= cnt_sum > 9'd255 ? 8'hff : cnt_sum[7:0];
        end
    end
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_flat
        assign x_flat[i*X_W +: X_W] = x_q[i];
        assign y_flat[i*Y_W +: Y_W] = y_q[i];
    end
endmodule

// File: doc/obj_slot_bank.md
OBJ_SLOT_BANK -- requirements
Module: obj_slot_bank

Parameters
REQ-001 The block SHALL have parameter N_SLOTS, default 10, number of object slots.
REQ-002 The block SHALL have parameter LANE_W, default 4, lane index width.
REQ-003 The block SHALL have parameter N_LANES, default 12, number of legal lanes (0..N_LANES-1).
REQ-004 The block SHALL have parameter X_W, default 8, x coordinate width.
REQ-005 The block SHALL have parameter Y_W, default 7, y coordinate width.
REQ-006 The block SHALL have parameters LANE_PITCH (default 10), LANE_OFFSET (default 2), Y_MAX (default 119) and Y_STEP (default 1).

Interface
REQ-007 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-009 The block SHALL have port spawn, input, 1, request to place a new object.
REQ-010 The block SHALL have port lane, input, LANE_W, lane of the spawn request.
REQ-011 The block SHALL have port spawn_ack, output, 1, combinational: spawn accepted this cycle.
REQ-012 The block SHALL have port spawn_err, output, 1, combinational: spawn rejected this cycle (full or illegal lane).
REQ-013 The block SHALL have port tick, input, 1, single-cycle strobe that advances all objects.
REQ-014 The block SHALL have ports clr and clr_idx, inputs, 1 and ceil(log2(N_SLOTS)), request to free one slot (hit).
REQ-015 The block SHALL have ports valid, x_flat and y_flat, outputs, widths N_SLOTS, N_SLOTS*X_W and N_SLOTS*Y_W; slot i occupies bits [i*W +: W].
REQ-016 The block SHALL have ports full (1), count (ceil(log2(N_SLOTS+1))), miss (1, registered pulse) and miss_cnt (8, saturating), all outputs.

Function
REQ-017 spawn_ack SHALL be 1 iff spawn=1, lane<N_LANES and at least one slot was invalid at the start of the cycle; spawn_err SHALL be spawn & ~spawn_ack.
REQ-018 On acceptance, the lowest-index invalid slot SHALL be loaded at the edge: valid=1, x=lane*LANE_PITCH+LANE_OFFSET truncated to X_W, y=0.
REQ-019 On tick, every valid slot not loaded in that cycle SHALL have y <= y+Y_STEP if y+Y_STEP <= Y_MAX (computed at Y_W+1 bits); otherwise the slot SHALL become invalid (retire).
REQ-020 A slot loaded in the same cycle as tick SHALL hold y=0 and SHALL NOT be advanced.
REQ-021 miss SHALL pulse for exactly one cycle, in the cycle after any retire; multiple retires on one tick SHALL add that number to miss_cnt, which SHALL saturate at 255.
REQ-022 clr with a valid clr_idx slot SHALL invalidate it at the edge; clr on an invalid slot or on clr_idx>=N_SLOTS SHALL have no effect.
REQ-023 clr and retire of the same slot in one cycle: clr SHALL win; no miss, miss_cnt unchanged.
REQ-024 A slot freed (by clr or retire) in cycle t SHALL NOT be allocatable before cycle t+1; full SHALL reflect registered valid only.
REQ-025 count SHALL equal popcount(valid) and full SHALL equal (count==N_SLOTS), both derived from registered valid.
REQ-026 x and y of an invalid slot SHALL hold their last values; consumers SHALL qualify them with valid.

Reset
REQ-027 When reset_n=0 at a rising edge, all valid, x, y, miss and miss_cnt SHALL become 0; spawn, tick and clr in that cycle SHALL be ignored.
REQ-028 While reset_n=0, spawn_ack SHALL be 0 and spawn_err SHALL equal spawn.
REQ-029 Reset asserted mid-operation SHALL discard all objects within one edge; no miss SHALL be generated by the reset.

Verification
REQ-030 After reset, spawn with lane=3 for one cycle -> spawn_ack=1, next cycle valid=0x001, x0=32, y0=0, count=1.
REQ-031 Spawn on 10 consecutive cycles with lanes 0..9 -> slots 0..9 filled with x=2,12,..,92; full=1; 11th spawn -> spawn_err=1, state unchanged.
REQ-032 One object, apply 119 ticks -> y=119, still valid; 120th tick -> valid=0, miss=1 for one cycle, miss_cnt=1.
REQ-033 Slot 0 at y=119, clr with clr_idx=0 and tick in the same cycle -> valid=0, miss never asserts, miss_cnt=0.
REQ-034 Full bank, clr slot 4 in cycle t with spawn lane=1 -> spawn_err=1 at t; spawn at t+1 -> ack, slot 4 loaded with x=12, y=0.
REQ-035 Spawn lane=12 (>=N_LANES) -> spawn_err=1, no slot changes; reset_n=0 with 5 live objects -> next cycle valid=0, count=0, miss=0.
